// File: rtl/mot_comm_sched.sv
// Open-loop six-step BLDC commutation scheduler: align/ramp/run step timing,
// per-step dead time, fault latch and enable gating in front of the gate drivers.
module mot_comm_sched #(
    parameter int unsigned PW           = 24,
    parameter int unsigned ALIGN_CYC    = 32000,
    parameter int unsigned START_PERIOD = 320000,
    parameter int unsigned MIN_PERIOD   = 64,
    parameter int unsigned DEAD_CYC     = 16
) (
    input  logic          MOT_CLK,
    input  logic          MOT_RST,
    input  logic          en_i,
    input  logic          dir_i,
    input  logic          fault_i,
    input  logic [PW-1:0] target_period_i,
    input  logic [PW-1:0] ramp_dec_i,
    output logic [5:0]    pwm_out_o,
    output logic [2:0]    step_idx_o,
    output logic          step_stb_o,
    output logic          running_o,
    output logic          at_speed_o,
    output logic          fault_lat_o
);

    typedef enum logic [2:0] {StIdle, StAlign, StRamp, StRun, StFault} state_e;

    localparam logic [PW-1:0] AlignCyc    = PW'(ALIGN_CYC);
    localparam logic [PW-1:0] StartPeriod = PW'(START_PERIOD);
    localparam logic [PW-1:0] MinPeriod   = PW'(MIN_PERIOD);
    localparam logic [PW-1:0] DeadCyc     = PW'(DEAD_CYC);

    state_e        state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [PW-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [PW-1:0] cur_period_q, cur_period_d;
    logic          stb_q, stb_d;
    logic          fault_lat_q, fault_lat_d;

    logic [PW-1:0] tgt;
    logic [PW-1:0] ramp_nxt;
    logic [2:0]    step_adv;
    logic          active;
    logic          step_end;

    function automatic logic [5:0] step_pattern(input logic [2:0] idx);
        logic [5:0] pat;
        case (idx)
            3'd0:    pat = 6'b100110;
            3'd1:    pat = 6'b100101;
            3'd2:    pat = 6'b101001;
            3'd3:    pat = 6'b011001;
            3'd4:    pat = 6'b011010;
            3'd5:    pat = 6'b010110;
            default: pat = 6'b000000;
        endcase
        return pat;
    endfunction

    always_comb begin
        tgt      = (target_period_i < MinPeriod) ? MinPeriod : target_period_i;
        ramp_nxt = (ramp_dec_i >= cur_period_q) ? '0 : cur_period_q - ramp_dec_i;
        active   = (state_q == StAlign) || (state_q == StRamp) || (state_q == StRun);
        // cur_period_q is never 0 while active, so the subtraction cannot wrap.
        step_end = active && (cyc_cnt_q == cur_period_q - PW'(1));
        if (dir_i) begin
            step_adv = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
        end else begin
            step_adv = (step_q == 3'd0) ? 3'd5 : step_q - 3'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        cyc_cnt_d    = cyc_cnt_q;
        cur_period_d = cur_period_q;
        stb_d        = 1'b0;
        fault_lat_d  = fault_lat_q;

        // Fault outranks enable and any step boundary in the same cycle.
        if (fault_i) begin
            state_d     = StFault;
            fault_lat_d = 1'b1;
            cyc_cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (en_i) begin
                        state_d      = StAlign;
                        step_d       = 3'd0;
                        cyc_cnt_d    = '0;
                        cur_period_d = AlignCyc;
                        stb_d        = 1'b1;
                    end
                end
                StFault: begin
                    if (!en_i) begin
                        state_d     = StIdle;
                        fault_lat_d = 1'b0;
                    end
                end
                StAlign, StRamp, StRun: begin
                    if (!en_i) begin
                        state_d   = StIdle;
                        cyc_cnt_d = '0;
                    end else if (step_end) begin
                        step_d    = step_adv;
                        cyc_cnt_d = '0;
                        stb_d     = 1'b1;
                        case (state_q)
                            StAlign: begin
                                if (tgt < StartPeriod) begin
                                    state_d      = StRamp;
                                    cur_period_d = StartPeriod;
                                end else begin
                                    state_d      = StRun;
                                    cur_period_d = tgt;
                                end
                            end
                            StRamp: begin
                                if (ramp_nxt <= tgt) begin
                                    state_d      = StRun;
                                    cur_period_d = tgt;
                                end else begin
                                    cur_period_d = ramp_nxt;
                                end
                            end
                            default: cur_period_d = tgt;
                        endcase
                    end else begin
                        cyc_cnt_d = cyc_cnt_q + PW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge MOT_CLK or posedge MOT_RST) begin
        if (MOT_RST) begin
            state_q      <= StIdle;
            step_q       <= 3'd0;
            cyc_cnt_q    <= '0;
            cur_period_q <= '0;
            stb_q        <= 1'b0;
            fault_lat_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            cyc_cnt_q    <= cyc_cnt_d;
            cur_period_q <= cur_period_d;
            stb_q        <= stb_d;
            fault_lat_q  <= fault_lat_d;
        end
    end

    // Bridge is all-off outside active states and for the first DEAD_CYC cycles of a step.
    assign pwm_out_o   = (active && (cyc_cnt_q >= DeadCyc)) ? step_pattern(step_q) : 6'b000000;
    assign step_idx_o  = step_q;
    assign step_stb_o  = stb_q;
    assign running_o   = active;
    assign at_speed_o  = (state_q == StRun);
    assign fault_lat_o = fault_lat_q;

endmodule
